// File: rtl/drop_pkg.sv
// Shared types and constants for the drop timer source block.
package drop_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COUNT,
      RELEASE
   } state_t;

   localparam int DATA_WIDTH_DEF = 2 * 8;

   localparam logic [DATA_WIDTH_DEF-1:0] T_SAT = '1;

endpackage

// File: rtl/drop_prescaler.sv
// Clock prescaler: counts 0..PRESCALE-1 while enabled.
// The tick marks the last count, the cycle on which the counter wraps.
module drop_prescaler #(
   parameter int PRESCALE = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = en & ~clr & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/drop_timer_ctrl.sv
// Drop timer source: latches t_lim, times t_act, then opens a
// fixed-length drop_en window once t_act reaches t_lim.
module drop_timer_ctrl
   import drop_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE   = 1000,
   parameter int DROP_HOLD  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] t_lim_in,
   input  logic                  t_lim_valid,
   output logic                  t_lim_ready,
   input  logic                  start,
   input  logic                  abort,
   output logic [DATA_WIDTH-1:0] t_act,
   output logic [DATA_WIDTH-1:0] t_lim,
   output logic                  drop_en,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] SAT = '1;
   localparam int HW = $clog2(DROP_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(DROP_HOLD - 1);

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          tick;
   logic          take;
   logic          reached;
   logic          pre_clr;
   logic          pre_en;

   assign take    = t_lim_valid & t_lim_ready;
   assign reached = (t_act >= t_lim);
   assign pre_en  = (state == COUNT);
   assign pre_clr = abort
                  | ((state == ARMED) & start)
                  | ((state == COUNT) & reached);

   drop_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_pre (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (tick)
   );

   // t_lim_ready and busy are registered alongside every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         t_act       <= '0;
         t_lim       <= '0;
         drop_en     <= 1'b0;
         busy        <= 1'b0;
         t_lim_ready <= 1'b1;
         hold_cnt    <= '0;
      end else if (abort) begin
         state       <= IDLE;
         t_act       <= '0;
         drop_en     <= 1'b0;
         busy        <= 1'b0;
         t_lim_ready <= 1'b1;
         hold_cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  t_lim <= t_lim_in;
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (take) begin
                  t_lim <= t_lim_in;
               end
               if (start) begin
                  state       <= COUNT;
                  t_act       <= '0;
                  busy        <= 1'b1;
                  t_lim_ready <= 1'b0;
               end
            end
            COUNT: begin
               if (reached) begin
                  state    <= RELEASE;
                  drop_en  <= 1'b1;
                  hold_cnt <= '0;
               end else if (tick && (t_act != SAT)) begin
                  t_act <= t_act + 1'b1;
               end
            end
            RELEASE: begin
               if (hold_cnt == HOLD_LAST) begin
                  state       <= IDLE;
                  drop_en     <= 1'b0;
                  busy        <= 1'b0;
                  t_lim_ready <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drop_timer_ctrl.sv
// Directed bench for drop_timer_ctrl (PRESCALE=4, DROP_HOLD=3).
module tb_drop_timer_ctrl;
   import drop_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] t_lim_in;
   logic        t_lim_valid;
   logic        t_lim_ready;
   logic        start;
   logic        abort;
   logic [15:0] t_act;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        busy;

   int checks = 0;
   int errors = 0;

   drop_timer_ctrl #(
      .DATA_WIDTH(16),
      .PRESCALE  (4),
      .DROP_HOLD (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .t_lim_in   (t_lim_in),
      .t_lim_valid(t_lim_valid),
      .t_lim_ready(t_lim_ready),
      .start      (start),
      .abort      (abort),
      .t_act      (t_act),
      .t_lim      (t_lim),
      .drop_en    (drop_en),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [15:0] v);
      t_lim_in    = v;
      t_lim_valid = 1'b1;
      step();
      t_lim_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      t_lim_in    = 16'h0;
      t_lim_valid = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      repeat (2) step();
      chk("rst_t_act", t_act, 16'h0);
      chk("rst_t_lim", t_lim, 16'h0);
      chk("rst_drop", 16'(drop_en), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_ready", 16'(t_lim_ready), 16'h1);
      rst_n = 1'b1;
      step();

      // 1: async reset while counting
      offer(16'h0005);
      chk("t1_lim", t_lim, 16'h0005);
      pulse_start();
      chk("t1_busy", 16'(busy), 16'h1);
      chk("t1_ready", 16'(t_lim_ready), 16'h0);
      repeat (5) step();
      chk("t1_act1", t_act, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_act", t_act, 16'h0);
      chk("t1_async_lim", t_lim, 16'h0);
      chk("t1_async_busy", 16'(busy), 16'h0);
      chk("t1_async_drop", 16'(drop_en), 16'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("t1_idle_ready", 16'(t_lim_ready), 16'h1);
      chk("t1_idle_busy", 16'(busy), 16'h0);

      // 2: t_lim = 5 full run
      offer(16'h0005);
      pulse_start();
      chk("t2_act0", t_act, 16'h0);
      for (int k = 1; k <= 5; k++) begin
         repeat (3) step();
         chk("t2_pre", t_act, 16'(k - 1));
         step();
         chk("t2_inc", t_act, 16'(k));
         chk("t2_nodrop", 16'(drop_en), 16'h0);
      end
      step();
      chk("t2_drop1", 16'(drop_en), 16'h1);
      chk("t2_busy1", 16'(busy), 16'h1);
      step();
      chk("t2_drop2", 16'(drop_en), 16'h1);
      step();
      chk("t2_drop3", 16'(drop_en), 16'h1);
      chk("t2_hold_act", t_act, 16'h0005);
      step();
      chk("t2_drop_off", 16'(drop_en), 16'h0);
      chk("t2_busy_off", 16'(busy), 16'h0);
      chk("t2_keep_act", t_act, 16'h0005);
      chk("t2_keep_lim", t_lim, 16'h0005);
      chk("t2_ready", 16'(t_lim_ready), 16'h1);

      // 3: zero limit
      offer(16'h0000);
      pulse_start();
      chk("t3_e1_drop", 16'(drop_en), 16'h0);
      chk("t3_e1_busy", 16'(busy), 16'h1);
      step();
      chk("t3_e2_drop", 16'(drop_en), 16'h1);
      chk("t3_act", t_act, 16'h0);
      repeat (2) step();
      chk("t3_e4_drop", 16'(drop_en), 16'h1);
      step();
      chk("t3_end_drop", 16'(drop_en), 16'h0);
      chk("t3_end_act", t_act, 16'h0);

      // 4: abort mid-count
      offer(16'h0005);
      pulse_start();
      repeat (8) step();
      chk("t4_act2", t_act, 16'h0002);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_act", t_act, 16'h0);
      chk("t4_drop", 16'(drop_en), 16'h0);
      chk("t4_busy", 16'(busy), 16'h0);
      chk("t4_ready", 16'(t_lim_ready), 16'h1);
      chk("t4_lim", t_lim, 16'h0005);
      pulse_start();
      repeat (4) step();
      chk("t4_ign_busy", 16'(busy), 16'h0);
      chk("t4_ign_act", t_act, 16'h0);
      offer(16'h0005);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("t4_both_busy", 16'(busy), 16'h0);
      pulse_start();
      chk("t4_norearm", 16'(busy), 16'h0);

      // 5: handshake back-pressure and overwrite
      offer(16'h0003);
      pulse_start();
      t_lim_in    = 16'h0007;
      t_lim_valid = 1'b1;
      step();
      chk("t5_ready0", 16'(t_lim_ready), 16'h0);
      chk("t5_nolat", t_lim, 16'h0003);
      repeat (11) step();
      chk("t5_act3", t_act, 16'h0003);
      chk("t5_still", t_lim, 16'h0003);
      step();
      chk("t5_drop", 16'(drop_en), 16'h1);
      repeat (3) step();
      chk("t5_ready1", 16'(t_lim_ready), 16'h1);
      chk("t5_pre", t_lim, 16'h0003);
      step();
      chk("t5_xfer", t_lim, 16'h0007);
      t_lim_in = 16'h0009;
      step();
      t_lim_valid = 1'b0;
      chk("t5_over", t_lim, 16'h0009);

      // 6: saturation at all-ones
      offer(T_SAT);
      pulse_start();
      force dut.t_act = T_SAT - 16'h1;
      #1;
      release dut.t_act;
      chk("t6_forced", t_act, 16'hfffe);
      repeat (3) step();
      chk("t6_wait", t_act, 16'hfffe);
      step();
      chk("t6_sat", t_act, 16'hffff);
      chk("t6_nodrop", 16'(drop_en), 16'h0);
      step();
      chk("t6_drop", 16'(drop_en), 16'h1);
      chk("t6_nowrap", t_act, 16'hffff);
      repeat (3) step();
      chk("t6_off", 16'(drop_en), 16'h0);
      chk("t6_final", t_act, 16'hffff);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
